// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the neuron-layer datapath: FSM state encoding
// and default sizing used by the activation arbiter and the layer sequencer.
package nn_ctrl_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 16;
    localparam int DEF_TIMEOUT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

endpackage

// File: rtl/cordic_af_arbiter_if.sv
// Bundle between the neuron lanes / CORDIC core and the activation arbiter.
// The arbiter uses the slave view; lanes plus core together form the master.
interface cordic_af_arbiter_if
    import nn_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] operand;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               cordic_start;
    logic [DW-1:0]      cordic_in;
    logic               cordic_done;
    logic [DW-1:0]      cordic_out;
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  req, operand, cordic_done, cordic_out,
        output gnt, rsp_valid, rsp_data, cordic_start, cordic_in, busy, timeout_err
    );

    modport master (
        output req, operand, cordic_done, cordic_out,
        input  gnt, rsp_valid, rsp_data, cordic_start, cordic_in, busy, timeout_err
    );

endinterface

// File: rtl/cordic_af_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, with wrap,
// so the lane granted last has the lowest priority next time.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   owner,
    output logic            any_req
);

    logic [IW-1:0] idx;

    always_comb begin
        idx     = ptr;
        owner   = '0;
        any_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                owner   = idx;
            end
        end
    end

endmodule

// File: rtl/cordic_af_arbiter.sv
// Shares one iterative CORDIC activation core among NREQ neuron lanes:
// round-robin arbitration, launch, watchdog on completion, and result routing.
module cordic_af_arbiter
    import nn_ctrl_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 rst_n,
    cordic_af_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, ptr_q, arb_owner;
    logic            arb_any;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] gnt_q, rsp_valid_q;
    logic            start_q, timeout_err_q;
    logic [DW-1:0]   rsp_data_q, cordic_in_q;
    logic [DW-1:0]   lane_op [NREQ];
    logic            arb_take, done_take, timeout_hit;

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        assign lane_op[k] = bus.operand[k*DW +: DW];
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .owner   (arb_owner),
        .any_req (arb_any)
    );

    // RESP arbitrates like IDLE so a waiting lane issues back-to-back.
    always_comb begin
        state_d     = state_q;
        arb_take    = 1'b0;
        done_take   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    arb_take = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.cordic_done) begin
                    done_take = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            RESP: begin
                if (arb_any) begin
                    arb_take = 1'b1;
                    state_d  = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses are registered on the transition into ISSUE/RESP so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            ptr_q         <= IW'(NREQ - 1);
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            start_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            rsp_data_q    <= '0;
            cordic_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            start_q     <= 1'b0;
            if (arb_take) begin
                owner_q     <= arb_owner;
                ptr_q       <= arb_owner;
                cordic_in_q <= lane_op[arb_owner];
                gnt_q       <= NREQ'(1) << arb_owner;
                start_q     <= 1'b1;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (done_take) begin
                rsp_data_q  <= bus.cordic_out;
                rsp_valid_q <= NREQ'(1) << owner_q;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.cordic_start = start_q;
    assign bus.cordic_in    = cordic_in_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_cordic_af_arbiter.sv
// Directed bench for cordic_af_arbiter: a vector table of single transactions
// plus hand-written round-robin, back-to-back, timeout and reset sequences.
module tb_cordic_af_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*DW-1:0] ops;
        int                 lat;
        logic [DW-1:0]      out;
        int                 lane;
        logic [DW-1:0]      exp_in;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [7];

    cordic_af_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    cordic_af_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request from idle: gnt at cycle 1, done at cycle 1+lat, rsp_valid at cycle 2+lat.
    task automatic apply_stimulus(input vec_t v, input string tag);
        logic [NREQ-1:0] exp_gnt;
        logic            spurious;
        exp_gnt = NREQ'(1) << v.lane;
        @(negedge clk);
        bus.req         = v.req;
        bus.operand     = v.ops;
        bus.cordic_done = 1'b0;
        @(negedge clk);
        check_output({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        check_output({tag, "_start"}, 32'(bus.cordic_start), 32'd1);
        check_output({tag, "_cordic_in"}, 32'(bus.cordic_in), 32'(v.exp_in));
        bus.req     = '0;
        bus.operand = ~v.ops;
        spurious    = 1'b0;
        for (int c = 2; c <= v.lat + 1; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0 || bus.gnt != 0 || bus.cordic_start || !bus.busy)
                spurious = 1'b1;
        end
        bus.cordic_done = 1'b1;
        bus.cordic_out  = v.out;
        @(negedge clk);
        check_output({tag, "_quiet_wait"}, 32'(spurious), 32'd0);
        check_output({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_gnt));
        check_output({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(v.out));
        check_output({tag, "_in_stable"}, 32'(bus.cordic_in), 32'(v.exp_in));
        bus.cordic_done = 1'b0;
        bus.cordic_out  = 16'h5A5A;
        @(negedge clk);
        check_output({tag, "_rsp_off"}, 32'(bus.rsp_valid), 32'd0);
        check_output({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check_output({tag, "_data_held"}, 32'(bus.rsp_data), 32'(v.out));
    endtask

    initial begin
        int              rr_exp [5];
        int              gi, ri, cd;
        logic [NREQ-1:0] last_gnt;
        logic            spurious;

        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.req         = '0;
        bus.operand     = '0;
        bus.cordic_done = 1'b0;
        bus.cordic_out  = '0;

        // Expected lanes assume the pointer left by the previous row (reset leaves lane 3).
        vecs[0] = '{4'b0001, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 16, 16'h00C3, 0, 16'h0100};
        vecs[1] = '{4'b0101, {16'h1003, 16'h1002, 16'h1001, 16'h1000},  5, 16'h2222, 2, 16'h1002};
        vecs[2] = '{4'b0011, {16'h2003, 16'h2002, 16'h2001, 16'h2000},  1, 16'h3333, 0, 16'h2000};
        vecs[3] = '{4'b1000, {16'h3003, 16'h3002, 16'h3001, 16'h3000},  7, 16'h4444, 3, 16'h3003};
        vecs[4] = '{4'b0110, {16'h4003, 16'h4002, 16'h4001, 16'h4000},  2, 16'h5555, 1, 16'h4001};
        vecs[5] = '{4'b1010, {16'h5003, 16'h5002, 16'h5001, 16'h5000}, 10, 16'hFFFF, 3, 16'h5003};
        vecs[6] = '{4'b1111, {16'h6003, 16'h6002, 16'h6001, 16'h6000},  3, 16'h8000, 0, 16'h6000};

        do_reset();
        check_output("rst_gnt", 32'(bus.gnt), 32'd0);
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst_start", 32'(bus.cordic_start), 32'd0);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        check_output("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check_output("rst_cordic_in", 32'(bus.cordic_in), 32'd0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] round-robin with all lanes requesting");
        do_reset();
        rr_exp   = '{0, 1, 2, 3, 0};
        gi       = 0;
        ri       = 0;
        cd       = 0;
        last_gnt = '0;
        @(negedge clk);
        bus.req        = 4'b1111;
        bus.operand    = {16'h7003, 16'h7002, 16'h7001, 16'h7000};
        bus.cordic_out = 16'hC0DE;
        for (int c = 0; c < 200 && ri < 5; c++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                if (gi < 5) check_output($sformatf("rr_gnt%0d", gi), 32'(bus.gnt), 32'(NREQ'(1) << rr_exp[gi]));
                else        check_output("rr_extra_gnt", 32'(bus.gnt), 32'd0);
                last_gnt = bus.gnt;
                gi++;
                if (gi == 5) bus.req = '0;
            end
            if (bus.rsp_valid != 0) begin
                check_output($sformatf("rr_rsp%0d", ri), 32'(bus.rsp_valid), 32'(last_gnt));
                ri++;
            end
            bus.cordic_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) bus.cordic_done = 1'b1;
            end
            if (bus.cordic_start) cd = 3;
        end
        check_output("rr_complete", 32'(ri), 32'd5);
        bus.cordic_done = 1'b0;
        bus.req         = '0;
        @(negedge clk);
        check_output("rr_idle", 32'(bus.busy), 32'd0);

        $display("[TB] back-to-back issue from RESP");
        @(negedge clk);
        bus.req     = 4'b0100;
        bus.operand = {16'h8003, 16'h8002, 16'h8001, 16'h8000};
        @(negedge clk);
        check_output("b2b_gnt_lane2", 32'(bus.gnt), 32'b0100);
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        bus.cordic_done = 1'b1;
        bus.cordic_out  = 16'h1234;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        check_output("b2b_rsp_lane2", 32'(bus.rsp_valid), 32'b0100);
        check_output("b2b_rsp_data2", 32'(bus.rsp_data), 32'h1234);
        @(negedge clk);
        check_output("b2b_gnt_lane1", 32'(bus.gnt), 32'b0010);
        check_output("b2b_no_idle", 32'(bus.busy), 32'd1);
        check_output("b2b_cordic_in1", 32'(bus.cordic_in), 32'h8001);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        bus.cordic_done = 1'b1;
        bus.cordic_out  = 16'h4321;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        check_output("b2b_rsp_lane1", 32'(bus.rsp_valid), 32'b0010);
        check_output("b2b_rsp_data1", 32'(bus.rsp_data), 32'h4321);
        @(negedge clk);
        check_output("b2b_idle", 32'(bus.busy), 32'd0);

        $display("[TB] watchdog timeout");
        @(negedge clk);
        bus.req     = 4'b0001;
        bus.operand = {16'h9003, 16'h9002, 16'h9001, 16'h9000};
        @(negedge clk);
        check_output("to_gnt", 32'(bus.gnt), 32'b0001);
        bus.req  = '0;
        spurious = 1'b0;
        for (int c = 2; c <= TIMEOUT + 1; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0 || !bus.busy || bus.timeout_err) spurious = 1'b1;
        end
        check_output("to_quiet_wait", 32'(spurious), 32'd0);
        @(negedge clk);
        check_output("to_err_set", 32'(bus.timeout_err), 32'd1);
        check_output("to_idle", 32'(bus.busy), 32'd0);
        check_output("to_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.cordic_done = 1'b1;
        bus.cordic_out  = 16'hDEAD;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        check_output("late_done_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check_output("late_done_idle", 32'(bus.busy), 32'd0);
        check_output("late_done_data", 32'(bus.rsp_data), 32'h4321);
        apply_stimulus('{4'b0100, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 6, 16'h0BAD, 2, 16'hA002}, "after_to");
        check_output("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        bus.req     = 4'b0010;
        bus.operand = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        @(negedge clk);
        check_output("rw_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rw_gnt_zero", 32'(bus.gnt), 32'd0);
        check_output("rw_busy_zero", 32'(bus.busy), 32'd0);
        check_output("rw_err_zero", 32'(bus.timeout_err), 32'd0);
        check_output("rw_data_zero", 32'(bus.rsp_data), 32'd0);
        check_output("rw_in_zero", 32'(bus.cordic_in), 32'd0);
        rst_n           = 1'b1;
        bus.cordic_done = 1'b1;
        bus.cordic_out  = 16'hBEEF;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        check_output("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check_output("rw_still_idle", 32'(bus.busy), 32'd0);
        apply_stimulus('{4'b1111, {16'hC003, 16'hC002, 16'hC001, 16'hC000}, 4, 16'h7777, 0, 16'hC000}, "rw_ptr");

        $display("[TB] done coincides with last watchdog cycle");
        apply_stimulus('{4'b1000, {16'hD003, 16'hD002, 16'hD001, 16'hD000}, TIMEOUT, 16'h0F0F, 3, 16'hD003}, "edge");
        check_output("edge_no_err", 32'(bus.timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_af_arbiter.md
Name: cordic_af_arbiter

Overview:
- Shares one iterative CORDIC activation-function core among NREQ neuron lanes of the inference datapath.
- Accepts activation requests from lanes, arbitrates round-robin, and launches the core with the winning lane's pre-activation operand.
- Waits for core completion, then routes the result back to the owning lane with a one-cycle valid pulse.
- Sits between the neuron compute lanes and the single CORDIC core; the layer sequencer drives the lanes' af requests.

Parameters:
- NREQ, 4, number of requesting neuron lanes (2..8).
- DW, 16, operand/result width (fixed-point, passed through unmodified).
- TIMEOUT, 64, max cycles in WAIT before the core is declared hung (must exceed the core's iteration latency).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NREQ  per-lane activation request, level; held until gnt.
- operand  in  NREQ*DW  flat operand bus, lane k at [k*DW +: DW].
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- rsp_valid  out  NREQ  one-hot result-valid pulse, 1 cycle.
- rsp_data  out  DW  result, valid with rsp_valid, held afterwards.
- cordic_start  out  1  1-cycle launch pulse to the core.
- cordic_in  out  DW  captured operand to the core, stable from start until done.
- cordic_done  in  1  core completion pulse.
- cordic_out  in  DW  core result, valid with cordic_done.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky hang flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; gnt=0, rsp_valid=0, cordic_start=0, busy=0, timeout_err=0; rsp_data=0, cordic_in=0; rr pointer=NREQ-1 so lane 0 has first priority; watchdog counter=0. Reset mid-operation abandons the in-flight op with no rsp_valid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick the first set bit searching from (ptr+1) mod NREQ upward with wrap. Register owner and cordic_in=operand[owner]; ptr=owner; go to ISSUE. No req: stay in IDLE.
- ISSUE (1 cycle): gnt[owner]=1, cordic_start=1; counter=0; go to WAIT.
- WAIT: counter increments each cycle.
  - cordic_done=1: capture rsp_data=cordic_out; go to RESP.
  - Otherwise, if counter reaches TIMEOUT-1: set timeout_err=1; go to IDLE with no rsp_valid.
  - cordic_done and timeout in the same cycle: done wins.
- RESP (1 cycle): rsp_valid[owner]=1. RESP doubles as an arbitration cycle: any req goes straight to ISSUE (back-to-back), else IDLE.
- Latency: req seen in IDLE at cycle 0 gives gnt/start at cycle 1; done at cycle d gives rsp_valid at d+1. Minimum op period is 3 cycles plus core latency.
- cordic_done outside WAIT is ignored (stale/late done after timeout).
- req dropped before gnt: withdrawn, no grant. req still high in the cycle after gnt counts as a new request and competes fairly.
- operand is sampled only at arbitration; later changes have no effect on the in-flight op.
- gnt, rsp_valid and cordic_start are registered, never high two consecutive cycles for the same op, and at most one bit of each is set.

Decomposition:
- Package nn_ctrl_pkg: state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3), default DW, NREQ, TIMEOUT; shared with the layer sequencer.
- Sub-module rr_arbiter (NREQ): combinational round-robin pick from req and ptr, outputs owner index and any_req.
- FSM, capture registers and watchdog stay in cordic_af_arbiter.

Test Plan:
- Single request: reset, req=0001, operand0=0x0100, core model done 16 cycles after start with cordic_out=0x00C3 -> gnt=0001 at cycle 1, cordic_in=0x0100, rsp_valid=0001 with rsp_data=0x00C3 at cycle 18.
- Round-robin fairness: req=1111 held continuously -> grant order lanes 0,1,2,3,0; every rsp_valid matches its gnt lane.
- Back-to-back: req[2] held, req[1] raised during WAIT -> the RESP cycle for lane 2 is followed directly by ISSUE with gnt=0010, no IDLE cycle between them.
- Timeout: core never asserts done, TIMEOUT=64 -> timeout_err=1 after 64 WAIT cycles, no rsp_valid, return to IDLE. A later done pulse is ignored, and the next req is still served.
- Reset mid-WAIT: rst_n=0 for one cycle during WAIT, then done arrives -> all outputs zero, no rsp_valid, ptr reset so lane 0 wins the next 1111 request.
- Done and timeout together: done asserted exactly at counter=TIMEOUT-1 -> RESP with data, timeout_err stays 0.
